// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, MMIO map and defaults.
package data_mem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] MMIO_BASE_DEFAULT   = 32'hFFFF_0000;
  localparam int          DEPTH_WORDS_DEFAULT = 256;

  // Word offsets inside the 16-byte MMIO window (addr[3:2]).
  localparam logic [1:0] LED_OFS = 2'd0;
  localparam logic [1:0] SW_OFS  = 2'd1;
  localparam logic [1:0] CYC_OFS = 2'd2;

  // Only LED is writable; the last slot is unmapped for both directions.
  function automatic logic mmio_illegal(input logic is_write, input logic [1:0] ofs);
    return (ofs == 2'd3) || (is_write && (ofs != LED_OFS));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs such as board switches.
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        meta_reg[gi] <= 1'b0;
        sync_reg[gi] <= 1'b0;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: req/ack word accesses to an on-chip RAM or a small MMIO
// window (LED, switches, cycle counter), with a fixed number of wait states.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  input  logic [7:0]  sw,
  output logic [7:0]  led
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic        ack_reg, err_reg, rd_ram_reg;
  logic [31:0] rdata_reg;
  logic [7:0]  led_reg;
  logic [31:0] cyc_reg;
  logic [7:0]  sw_sync;

  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] ram_q;

  logic             enter_resp;
  logic             cur_we;
  logic [31:0]      cur_addr, cur_wdata;
  logic             is_mmio, acc_err, ram_wr, ram_rd;
  logic [1:0]       mmio_ofs;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      mmio_rdata;

  sync_2ff #(.WIDTH(8)) u_sw_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (sw),
    .q      (sw_sync)
  );

  // With zero wait states the access commits on the accepting edge, so the
  // live inputs are decoded in IDLE and the captured copy everywhere else.
  always_comb begin
    cur_we    = (state_reg == ST_IDLE) ? we    : we_reg;
    cur_addr  = (state_reg == ST_IDLE) ? addr  : addr_reg;
    cur_wdata = (state_reg == ST_IDLE) ? wdata : wdata_reg;
    is_mmio   = (cur_addr >= MMIO_BASE);
    mmio_ofs  = cur_addr[3:2];
    ram_idx   = cur_addr[IDX_W+1:2];
    acc_err   = (cur_addr[1:0] != 2'b00) ||
                (is_mmio ? mmio_illegal(cur_we, mmio_ofs)
                         : (cur_addr[31:2] >= 30'(DEPTH_WORDS)));
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_next = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (mmio_ofs)
      LED_OFS: mmio_rdata = {24'd0, led_reg};
      SW_OFS:  mmio_rdata = {24'd0, sw_sync};
      CYC_OFS: mmio_rdata = cyc_reg;
      default: mmio_rdata = 32'd0;
    endcase
  end

  // The RAM has no reset, so its strobes are held off while reset is asserted.
  assign ram_wr = arst_n && enter_resp && !acc_err && !is_mmio && cur_we;
  assign ram_rd = arst_n && enter_resp && !acc_err && !is_mmio && !cur_we;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      ack_reg    <= 1'b0;
      err_reg    <= 1'b0;
      rd_ram_reg <= 1'b0;
      rdata_reg  <= 32'd0;
      led_reg    <= 8'd0;
      cyc_reg    <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      cyc_reg    <= cyc_reg + 32'd1;
      if (state_reg == ST_IDLE && req) begin
        we_reg    <= we;
        addr_reg  <= addr;
        wdata_reg <= wdata;
      end
      ack_reg    <= enter_resp;
      err_reg    <= enter_resp && acc_err;
      rd_ram_reg <= ram_rd;
      rdata_reg  <= (enter_resp && !acc_err && is_mmio && !cur_we) ? mmio_rdata : 32'd0;
      if (enter_resp && !acc_err && is_mmio && cur_we)
        led_reg <= cur_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr)
      ram[ram_idx] <= cur_wdata;
    if (ram_rd)
      ram_q <= ram[ram_idx];
  end

  assign rdata = rd_ram_reg ? ram_q : rdata_reg;
  assign ack   = ack_reg;
  assign err   = err_reg;
  assign led   = led_reg;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the single-cycle MIPS core's data-memory interface: accepts word read/write requests over a req/ack handshake, serves them from an on-chip word RAM or a small memory-mapped I/O window, and inserts a parameterised number of wait states. It sits between the core (or its bus adapter) and the board I/O (LEDs, switches). Illegal accesses are reported with `err` instead of being silently dropped.

## Interface
- `DEPTH_WORDS`, 256: RAM depth in 32-bit words, power of two, max 4096.
- `WAIT_STATES`, 1: extra cycles between request acceptance and response, 0..15.
- `MMIO_BASE`, 32'hFFFF_0000: base of the 16-byte MMIO window.
- `clk`  in  1  single clock, rising edge.
- `arst_n`  in  1  asynchronous active-low reset.
- `req`  in  1  request valid; held by initiator until `ack`.
- `we`  in  1  1 = write, 0 = read; stable while `req` is high.
- `addr`  in  32  byte address; stable while `req` is high.
- `wdata`  in  32  write data; stable while `req` is high.
- `rdata`  out  32  read data, valid only while `ack` is high, else 0.
- `ack`  out  1  one-cycle response strobe.
- `err`  out  1  high with `ack` when the access was illegal.
- `sw`  in  8  asynchronous board switches.
- `led`  out  8  LED register.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req`=1 at an edge accepts the request and captures `we`/`addr`/`wdata`. Next state is RESP if `WAIT_STATES`=0, else WAIT with counter = `WAIT_STATES`-1.
- WAIT: the counter decrements each edge. At the edge where it is 0, the FSM goes to RESP.
- RESP: the access commits on the edge entering RESP.
  - A write updates the target.
  - A read loads `rdata`.
  - `err` is evaluated from the captured request.
- During the RESP cycle `ack`=1. The next edge always returns the FSM to IDLE.
- Address decode:
  - `addr[1:0]`≠0: error.
  - `addr` ≥ `MMIO_BASE`: MMIO, offset `addr[3:2]`.
  - Otherwise RAM, word index `addr[31:2]`. Index ≥ `DEPTH_WORDS` is an error.
- MMIO map:
  - 0x0 LED: R/W, bits [7:0]; reads zero-extend.
  - 0x4 SW: RO, 2-flop synchronised `sw`.
  - 0x8 CYCLE: RO, free-running 32-bit counter that wraps 0xFFFF_FFFF→0.
  - 0xC: unmapped, error.
- A write to SW or CYCLE is an error.
- An error response has `rdata`=0 and no state change.
- RAM contents are not reset. Reads of never-written words return X in simulation.

## Timing
- Reset values: state IDLE, `ack`=0, `err`=0, `rdata`=0, `led`=0, CYCLE=0, sync flops 0.
- Latency: a request accepted at edge E0 produces `ack` in the cycle after edge E0+`WAIT_STATES`, i.e. `WAIT_STATES`+1 cycles.
- `ack`, `err` and `rdata` are registered. They are high/valid for exactly one cycle.
- `req` is ignored in WAIT and RESP.
- The initiator drops `req` in the cycle after `ack`. If `req` is still high in IDLE, it is treated as a new request. Back-to-back throughput is one access per `WAIT_STATES`+2 cycles.
- Read-after-write to the same word returns the new data.
- CYCLE read value is the counter value at the edge entering RESP.
- `sw` changes appear in the SW register 2 edges later.
- Reset mid-transaction returns the FSM to IDLE immediately with no `ack`. A write already committed (RESP entered) stays committed; a write still in WAIT is discarded.

## Structure
- A shared package/header holds:
  - the FSM state encoding;
  - `MMIO_BASE` default;
  - MMIO offsets `LED_OFS`=0, `SW_OFS`=1, `CYC_OFS`=2;
  - the default depth.
- Sub-module `sync_2ff` (parameterised width) synchronises `sw`.
- RAM is an inferred synchronous array inside this block, with one write port and one read port, both clocked on the RESP-entry edge.

## Test plan
- Reset, then write 0xDEADBEEF to 0x0000_0010 and read it back with `WAIT_STATES`=1. Required:
  - each `ack` arrives 2 cycles after acceptance;
  - the read returns 0xDEADBEEF with `err`=0.
- With `WAIT_STATES`=0, write 0xA5 to `MMIO_BASE`+0 and hold `req` high through `ack`. Required:
  - `led`=0xA5 the cycle after `ack`;
  - the held `req` is re-accepted, so `ack` pulses every 2 cycles.
- Read `addr`=0x0000_0402 (misaligned) and `addr`=0x0000_0400 (index 256, out of range). Required: `ack`=1, `err`=1, `rdata`=0 for both, and no RAM changes.
- Drive `sw`=0x3C, wait 3 cycles, then read `MMIO_BASE`+4. Required: `rdata`=0x0000_003C. Write `MMIO_BASE`+4. Required: `err`=1.
- Read CYCLE twice, back-to-back, with `WAIT_STATES`=1. Required: the difference is exactly 3.
- Assert `arst_n` low while in WAIT with a pending write to 0x20, having first written 0x1111_1111 to 0x20. Required:
  - no `ack`;
  - `led`=0;
  - a later read of 0x20 returns 0x1111_1111, proving the discarded write did not commit.
